// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller for the instruction fetch stage.
// Owns the PC and decides each cycle whether fetch advances, holds, redirects,
// drains toward a halt, or faults on an out-of-range PC. Drives the IF/ID
// load (fetch_en) and bubble (flush) controls.
module fetch_sequencer #(
    parameter int SIZE         = 32,
    parameter int DEPTH        = 32,
    parameter int RESET_PC     = 0,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [SIZE-1:0] redirect_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [SIZE-1:0] pc,
    output logic            fetch_en,
    output logic            flush,
    output logic            halted,
    output logic            fault
);

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [SIZE-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             in_range;

    assign in_range = (pc < SIZE'(DEPTH));

    // State, PC and drain counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values computed by the combinational block.
        if (rst) begin
            state <= RUN;
            pc    <= SIZE'(RESET_PC);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, next-PC and IF/ID controls, resolved by priority per state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        fetch_en  = 1'b0;
        flush     = 1'b0;

        unique case (state)
            RUN: begin
                if (!in_range) begin
                    // Fetching from outside the instruction memory: freeze and
                    // fault; nothing but reset is honoured from here on.
                    state_nxt = FAULT;
                end else if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    flush  = 1'b1;
                end else if (halt_req) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                end else if (!stall) begin
                    fetch_en = 1'b1;
                    pc_nxt   = pc + SIZE'(1);
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    // The halt was on a mispredicted path; abandon it.
                    pc_nxt    = redirect_target;
                    flush     = 1'b1;
                    state_nxt = RUN;
                end else if (cnt == '0) begin
                    state_nxt = HALT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HALT: begin
                if (resume) begin
                    pc_nxt    = pc + SIZE'(1);
                    state_nxt = RUN;
                end
            end
            FAULT: begin
                // Sticky until reset.
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase

        // Reset overrides the controls: load a bubble and capture nothing.
        if (rst) begin
            fetch_en = 1'b0;
            flush    = 1'b1;
        end
    end

    // Status flags from the registered state, masked while reset is applied.
    assign halted = (state == HALT)  && !rst;
    assign fault  = (state == FAULT) && !rst;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Each scenario task pushes the
// expected outputs of a cycle into a scoreboard as it drives that cycle's
// stimulus, and pops/compares once the outputs have settled.
module tb_fetch_sequencer;

    localparam int SIZE = 32;
    localparam logic [4:0] ALL = 5'b11111;   // pc, fetch_en, flush, halted, fault
    localparam logic [4:0] NOPC = 5'b01111;  // pc unspecified (leftover value)
    localparam logic [4:0] CTRL = 5'b01100;  // fetch_en and flush only

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [SIZE-1:0] redirect_target = '0;
    logic            halt_req = 1'b0;
    logic            resume = 1'b0;
    logic [SIZE-1:0] pc;
    logic            fetch_en, flush, halted, fault;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic            r, st, rv;
        logic [SIZE-1:0] tgt;
        logic            hr, rs;
    } stim_t;

    typedef struct packed {
        logic [SIZE-1:0] pc;
        logic            fe, fl, ha, fa;
        logic [4:0]      mask;
    } exp_t;

    exp_t sb[$];

    fetch_sequencer #(
        .SIZE(SIZE), .DEPTH(32), .RESET_PC(0), .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .resume(resume),
        .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t S(logic r, logic st, logic rv, int tgt, logic hr, logic rs);
        S = '{r: r, st: st, rv: rv, tgt: SIZE'(tgt), hr: hr, rs: rs};
    endfunction

    function automatic exp_t E(int p, logic fe, logic fl, logic ha, logic fa, logic [4:0] m);
        E = '{pc: SIZE'(p), fe: fe, fl: fl, ha: ha, fa: fa, mask: m};
    endfunction

    function automatic stim_t IDLE();
        IDLE = S(0, 0, 0, 0, 0, 0);
    endfunction

    // Apply one cycle of stimulus after the falling edge; outputs settle
    // before the next rising edge.
    task automatic drive(stim_t s);
        @(negedge clk);
        rst             = s.r;
        stall           = s.st;
        redirect_valid  = s.rv;
        redirect_target = s.tgt;
        halt_req        = s.hr;
        resume          = s.rs;
        #4;
    endtask

    task automatic test_reset();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        for (int i = 0; i < 2; i++) begin
            st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, ALL));
        end
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL reset[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        for (int i = 0; i < 6; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL sequential[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, NOPC));
        for (int i = 0; i < 4; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        st.push_back(S(0, 1, 0, 0, 0, 0));  ex.push_back(E(4, 0, 0, 0, 0, ALL));
        st.push_back(S(0, 1, 0, 0, 0, 0));  ex.push_back(E(4, 0, 0, 0, 0, ALL));
        st.push_back(S(0, 1, 1, 20, 0, 0)); ex.push_back(E(4, 0, 1, 0, 0, ALL));
        st.push_back(IDLE());               ex.push_back(E(20, 1, 0, 0, 0, ALL));
        st.push_back(IDLE());               ex.push_back(E(21, 1, 0, 0, 0, ALL));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL stall_redirect[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_halt_resume();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, NOPC));
        for (int i = 0; i < 7; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        st.push_back(S(0, 0, 0, 0, 1, 0));  ex.push_back(E(7, 0, 0, 0, 0, ALL)); // halt_req
        st.push_back(IDLE());               ex.push_back(E(7, 0, 0, 0, 0, ALL)); // drain 1
        st.push_back(S(0, 1, 0, 0, 0, 1));  ex.push_back(E(7, 0, 0, 0, 0, ALL)); // drain 2, ignored
        st.push_back(S(0, 0, 0, 0, 1, 0));  ex.push_back(E(7, 0, 0, 0, 0, ALL)); // drain 3, ignored
        st.push_back(IDLE());               ex.push_back(E(7, 0, 0, 1, 0, ALL)); // halted
        st.push_back(S(0, 1, 1, 3, 1, 0)); ex.push_back(E(7, 0, 0, 1, 0, ALL)); // ignored in HALT
        st.push_back(S(0, 0, 0, 0, 0, 1));  ex.push_back(E(7, 0, 0, 1, 0, ALL)); // resume
        st.push_back(IDLE());               ex.push_back(E(8, 1, 0, 0, 0, ALL));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL halt_resume[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_drain_abort();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, NOPC));
        for (int i = 0; i < 5; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        st.push_back(S(0, 0, 0, 0, 1, 0));  ex.push_back(E(5, 0, 0, 0, 0, ALL)); // halt_req
        st.push_back(IDLE());               ex.push_back(E(5, 0, 0, 0, 0, ALL)); // drain 1
        st.push_back(S(0, 0, 1, 12, 0, 0)); ex.push_back(E(5, 0, 1, 0, 0, ALL)); // drain 2, abort
        for (int i = 0; i < 5; i++) begin
            st.push_back(IDLE()); ex.push_back(E(12 + i, 1, 0, 0, 0, ALL));
        end
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL drain_abort[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, NOPC));
        st.push_back(S(0, 0, 1, 10, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, ALL));
        st.push_back(S(0, 0, 1, 2, 1, 0));  ex.push_back(E(10, 0, 1, 0, 0, ALL)); // redirect beats halt
        st.push_back(S(0, 0, 1, 40, 0, 0)); ex.push_back(E(2, 0, 1, 0, 0, ALL));  // out-of-range target
        st.push_back(IDLE());               ex.push_back(E(40, 0, 0, 0, 0, ALL));
        st.push_back(IDLE());               ex.push_back(E(40, 0, 0, 0, 1, ALL));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_range_fault();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, CTRL)); // leaving FAULT
        st.push_back(IDLE());               ex.push_back(E(0, 1, 0, 0, 0, ALL));
        st.push_back(S(0, 0, 1, 31, 0, 0)); ex.push_back(E(1, 0, 1, 0, 0, ALL));
        st.push_back(IDLE());               ex.push_back(E(31, 1, 0, 0, 0, ALL));
        st.push_back(S(0, 0, 1, 3, 0, 0));  ex.push_back(E(32, 0, 0, 0, 0, ALL)); // ignored
        st.push_back(S(0, 0, 1, 5, 0, 1));  ex.push_back(E(32, 0, 0, 0, 1, ALL));
        st.push_back(S(0, 0, 0, 0, 1, 1));  ex.push_back(E(32, 0, 0, 0, 1, ALL));
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(32, 0, 1, 0, 0, 5'b11100));
        st.push_back(IDLE());               ex.push_back(E(0, 1, 0, 0, 0, ALL));
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL range_fault[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_t st[$]; exp_t ex[$]; exp_t e;
        logic [SIZE+3:0] got, want, m;
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 1, 0, 0, NOPC));
        for (int i = 0; i < 3; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        st.push_back(S(0, 0, 0, 0, 1, 0)); ex.push_back(E(3, 0, 0, 0, 0, ALL)); // halt_req
        st.push_back(IDLE());              ex.push_back(E(3, 0, 0, 0, 0, ALL)); // drain, cnt=2
        st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(3, 0, 1, 0, 0, ALL)); // rst, cnt=1
        for (int i = 0; i < 5; i++) begin
            st.push_back(IDLE()); ex.push_back(E(i, 1, 0, 0, 0, ALL));
        end
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            e = sb.pop_front();
            got = {pc, fetch_en, flush, halted, fault};
            want = {e.pc, e.fe, e.fl, e.ha, e.fa};
            m = {{SIZE{e.mask[4]}}, e.mask[3:0]};
            n_cmp++;
            if ((got & m) !== (want & m)) begin
                n_bad++;
                $display("FAIL reset_mid_drain[%0d]: got pc/fe/fl/ha/fa=%h want %h mask %b", i, got, want, e.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_halt_resume();
        test_drain_abort();
        test_back_to_back();
        test_range_fault();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
